// File: rtl/adder_req_arbiter.sv
// adder_req_arbiter
// Shares a single external registered adder between NUM_REQ requesters.
// A round-robin arbiter accepts one operand pair at a time. The block drives
// the adder, waits out its latency, captures the sum, and returns the sum
// together with the requester id on a valid/ready response channel.

module adder_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int ADD_LATENCY = 1,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH:0]           add_sum,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH:0]           rsp_sum,
  output logic                     busy
);

  localparam int CNT_W = $clog2(ADD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Round-robin search: first valid requester after the last accepted one, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  // Only the winner sees ready, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (!rst && (state == IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);
  assign sel_a  = req_a[int'(grant_idx) * WIDTH +: WIDTH];
  assign sel_b  = req_b[int'(grant_idx) * WIDTH +: WIDTH];
  assign busy   = (state != IDLE);

  // Operation sequencer: accept, drive adder, count its latency edges, then
  // capture on the edge after the adder output has settled and hold the
  // response until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      add_a      <= '0;
      add_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      wait_cnt   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            add_a      <= sel_a;
            add_b      <= sel_b;
            rsp_id     <= grant_idx;
            last_grant <= grant_idx;
            wait_cnt   <= CNT_W'(ADD_LATENCY);
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            rsp_sum   <= add_sum;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_req_arbiter.sv
// tb_adder_req_arbiter
// Directed bench for adder_req_arbiter with a one-cycle registered adder model
// attached to the add_a/add_b/add_sum ports. Inputs change and outputs are
// sampled on the falling clock edge.

module tb_adder_req_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic [8:0]  add_sum;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [8:0]  rsp_sum;
  logic        busy;

  int checks    = 0;
  int errors    = 0;
  int cycle_cnt = 0;

  adder_req_arbiter #(
    .NUM_REQ     (4),
    .WIDTH       (8),
    .ADD_LATENCY (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered adder with a latency of one edge.
  always @(posedge clk) add_sum <= {1'b0, add_a} + {1'b0, add_b};

  // Edge counter used to measure latency and accept spacing.
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Hard stop if something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] a,
                               input logic [31:0] b, input logic rr);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
  endtask

  // Waits (bounded) until a grant is showing; returns the upcoming accept edge.
  task automatic waitGrant(output int e_cycle);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 16; n++) begin
      #1;
      if (req_ready != 4'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("grant_seen", {31'b0, seen}, 32'd1);
    e_cycle = cycle_cnt + 1;
  endtask

  // Waits (bounded) for rsp_valid; returns the edge after which it was seen.
  task automatic waitRsp(output int r_cycle);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("rsp_seen", {31'b0, seen}, 32'd1);
    r_cycle = cycle_cnt;
  endtask

  // One complete operation with rsp_ready held high.
  task automatic doOp(input int id, input logic [8:0] exp_sum, input logic [7:0] ea,
                      input logic [7:0] eb, input bit drop, output int e);
    int r;
    waitGrant(e);
    checkOutput("grant_onehot", {28'b0, req_ready}, 32'(1 << id));
    @(negedge clk);
    if (drop) req_valid[id] = 1'b0;
    checkOutput("add_a", {24'b0, add_a}, {24'b0, ea});
    checkOutput("add_b", {24'b0, add_b}, {24'b0, eb});
    checkOutput("busy_wait", {31'b0, busy}, 32'd1);
    waitRsp(r);
    checkOutput("rsp_latency", 32'(r - e), 32'd2);
    checkOutput("rsp_id", {30'b0, rsp_id}, 32'(id));
    checkOutput("rsp_sum", {23'b0, rsp_sum}, {23'b0, exp_sum});
    @(negedge clk);
    checkOutput("rsp_done", {31'b0, rsp_valid}, 32'd0);
    checkOutput("busy_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int e0;
    int e1;
    int r;

    // Reset with every requester asserting valid.
    rst = 1'b1;
    applyStimulus(4'hF, 32'h03020100, 32'h1E140A00, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("rst_ready", {28'b0, req_ready}, 32'd0);
      checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_add_a", {24'b0, add_a}, 32'd0);
      checkOutput("rst_add_b", {24'b0, add_b}, 32'd0);
    end
    rst = 1'b0;

    // Round-robin across all four requesters, accepts every 4 cycles.
    doOp(0, 9'd0, 8'd0, 8'd0, 1'b0, e0);
    doOp(1, 9'd11, 8'd1, 8'd10, 1'b0, e1);
    checkOutput("rr_spacing_01", 32'(e1 - e0), 32'd4);
    doOp(2, 9'd22, 8'd2, 8'd20, 1'b0, e0);
    checkOutput("rr_spacing_12", 32'(e0 - e1), 32'd4);
    doOp(3, 9'd33, 8'd3, 8'd30, 1'b0, e1);
    checkOutput("rr_spacing_23", 32'(e1 - e0), 32'd4);
    doOp(0, 9'd0, 8'd0, 8'd0, 1'b0, e0);
    checkOutput("rr_spacing_30", 32'(e0 - e1), 32'd4);

    // Single operation from a lone requester 0.
    applyStimulus(4'b0001, 32'h00000003, 32'h00000007, 1'b1);
    doOp(0, 9'd10, 8'd3, 8'd7, 1'b1, e0);

    // Full-width result.
    applyStimulus(4'b0100, 32'h00FF0000, 32'h00FF0000, 1'b1);
    doOp(2, 9'h1FE, 8'd255, 8'd255, 1'b1, e0);

    // Backpressure on requester 3, others contending, operands changed after accept.
    applyStimulus(4'b1000, 32'h64000000, 32'h32000000, 1'b0);
    waitGrant(e0);
    checkOutput("bp_grant", {28'b0, req_ready}, 32'd8);
    @(negedge clk);
    applyStimulus(4'b0111, 32'h01010101, 32'h01010101, 1'b0);
    waitRsp(r);
    checkOutput("bp_latency", 32'(r - e0), 32'd2);
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("bp_rsp_id", {30'b0, rsp_id}, 32'd3);
      checkOutput("bp_rsp_sum", {23'b0, rsp_sum}, 32'd150);
      checkOutput("bp_ready", {28'b0, req_ready}, 32'd0);
      checkOutput("bp_busy", {31'b0, busy}, 32'd1);
      checkOutput("bp_add_a", {24'b0, add_a}, 32'd100);
      @(negedge clk);
    end
    applyStimulus(4'b0000, 32'h01010101, 32'h01010101, 1'b1);
    @(negedge clk);
    checkOutput("bp_handshake", {31'b0, rsp_valid}, 32'd0);
    checkOutput("bp_idle", {31'b0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("bp_single", {31'b0, rsp_valid}, 32'd0);

    // Reset in the middle of an operation for requester 1.
    applyStimulus(4'b0010, 32'h00000500, 32'h00000600, 1'b1);
    waitGrant(e0);
    checkOutput("abort_grant", {28'b0, req_ready}, 32'd2);
    @(negedge clk);
    checkOutput("abort_busy_wait", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    applyStimulus(4'b0000, 32'h00000500, 32'h00000600, 1'b1);
    @(negedge clk);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("abort_ready", {28'b0, req_ready}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    applyStimulus(4'b0110, 32'h00070500, 32'h00080600, 1'b1);
    doOp(1, 9'd11, 8'd5, 8'd6, 1'b1, e0);
    doOp(2, 9'd15, 8'd7, 8'd8, 1'b1, e1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
